mult_control: RTL and testbench

- Sequencing controller for the n-bit shift-add multiplier datapath: C / A / Q register, adder producing Sum.
- Accepts a start request and issues one load pulse to the register (via its reset input).
- Then issues exactly n single-cycle operations. Each is add_shift when the current multiplier LSB is 1, otherwise shift.
- Signals done and holds the product until the requester acknowledges.
- Sits between the top-level multiplier wrapper and the register, one instance per multiplier.

---
 rtl/mult_pkg.sv | 16 +
 rtl/mult_iter_counter.sv | 34 +++
 rtl/mult_control.sv | 92 +++++++++
 tb/tb_mult_control.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the shift-add multiplier controller.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    OP   = 2'd2,
    DONE = 2'd3
  } mult_state_t;

  // Iteration counter width: holds n-1 at most.
  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/mult_iter_counter.sv
// Down-counter for the n multiplier iterations: loads n-1, decrements to 0 and stops.
module mult_iter_counter
  import mult_pkg::*;
#(
  parameter int n = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load,
  input  logic                      dec,
  output logic [cnt_width(n)-1:0]   count,
  output logic                      zero
);

  localparam int W = cnt_width(n);
  localparam logic [W-1:0] LOAD_VAL = W'(n - 1);

  logic [W-1:0] count_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= LOAD_VAL;
    end else if (dec && (count_reg != '0)) begin
      // Saturates at zero; the FSM leaves OP on the zero cycle.
      count_reg <= count_reg - 1'b1;
    end
  end

  assign count = count_reg;
  assign zero  = (count_reg == '0);

endmodule

// File: rtl/mult_control.sv
// Sequencer for the n-bit shift-add multiplier: load, n add_shift/shift ops, then done until ack.
// Optional abort input enabled by defining MULT_CONTROL_ABORT_EN.
module mult_control
  import mult_pkg::*;
#(
  parameter int n = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic ack,
  input  logic q0,
`ifdef MULT_CONTROL_ABORT_EN
  input  logic abort,
`endif
  output logic reg_load,
  output logic add_shift,
  output logic shift,
  output logic busy,
  output logic done
);

  mult_state_t state_reg;
  mult_state_t state_next;

  logic [cnt_width(n)-1:0] count;
  logic                    cnt_zero;
  logic                    cnt_load;
  logic                    cnt_dec;
  logic                    abort_hit;

  assign cnt_load = (state_reg == LOAD);
  assign cnt_dec  = (state_reg == OP);

  mult_iter_counter #(.n(n)) u_iter_counter (
    .clock (clock),
    .reset (reset),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .count (count),
    .zero  (cnt_zero)
  );

`ifdef MULT_CONTROL_ABORT_EN
  assign abort_hit = abort && ((state_reg == LOAD) || (state_reg == OP));
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = LOAD;
      LOAD: state_next = OP;
      OP:   if (cnt_zero) state_next = DONE;
      DONE: if (ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Abort discards the partial product; reset still wins via the register.
    if (abort_hit) state_next = IDLE;
  end

  always_comb begin
    reg_load  = 1'b0;
    add_shift = 1'b0;
    shift     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_reg)
      LOAD: begin
        reg_load = 1'b1;
        busy     = 1'b1;
      end
      OP: begin
        busy      = 1'b1;
        add_shift = q0;
        shift     = ~q0;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_control.sv
// Scoreboard bench for mult_control (n=4): per-cycle expected outputs queued by the driver, checked by a monitor.
module tb_mult_control;

  localparam logic [4:0] E_IDLE = 5'b00000; // {reg_load, add_shift, shift, busy, done}
  localparam logic [4:0] E_LOAD = 5'b10010;
  localparam logic [4:0] E_OPA  = 5'b01010;
  localparam logic [4:0] E_OPS  = 5'b00110;
  localparam logic [4:0] E_DONE = 5'b00001;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b1;
  logic ack   = 1'b0;
  logic q0    = 1'b0;
`ifdef MULT_CONTROL_ABORT_EN
  logic abort = 1'b0;
`endif
  logic reg_load, add_shift, shift, busy, done;

  typedef struct {
    logic [4:0] exp;
    string      tag;
  } item_t;

  item_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mult_control #(.n(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .ack       (ack),
    .q0        (q0),
`ifdef MULT_CONTROL_ABORT_EN
    .abort     (abort),
`endif
    .reg_load  (reg_load),
    .add_shift (add_shift),
    .shift     (shift),
    .busy      (busy),
    .done      (done)
  );

  // Monitor: one comparison per cycle against the queued expectation.
  initial begin
    forever begin
      @(negedge clock);
      if (sb.size() != 0) begin
        item_t it;
        logic [4:0] act;
        it  = sb.pop_front();
        act = {reg_load, add_shift, shift, busy, done};
        checks++;
        if (act !== it.exp) begin
          errors++;
          $display("FAIL %s: got {reg_load,add_shift,shift,busy,done}=%b required %b", it.tag, act, it.exp);
        end else begin
          $display("ok   %s: outputs=%b", it.tag, act);
        end
      end
    end
  end

  // exp is this cycle's output (given q0 = qb); rst/st/ak are sampled at the next edge.
  task automatic step(input logic rst, input logic st, input logic ak, input logic qb,
                      input logic [4:0] exp, input string tag);
    @(posedge clock);
    #1;
    reset = rst;
    start = st;
    ack   = ak;
    q0    = qb;
    sb.push_back('{exp, tag});
  endtask

  initial begin
    // Reset held two edges with start high.
    step(1, 1, 0, 0, E_IDLE, "reset_cycle1");
    step(0, 1, 0, 0, E_IDLE, "reset_cycle2");
    // Multiplier 0101: LSB-first 1,0,1,0; ack pulses in OP are ignored.
    step(0, 0, 0, 0, E_LOAD, "m0101_load");
    step(0, 0, 0, 1, E_OPA,  "m0101_op1");
    step(0, 0, 1, 0, E_OPS,  "m0101_op2_ack_ignored");
    step(0, 0, 0, 1, E_OPA,  "m0101_op3");
    step(0, 0, 0, 0, E_OPS,  "m0101_op4");
    step(0, 0, 1, 0, E_DONE, "m0101_done");
    // Back in IDLE: start and ack together, start wins.
    step(0, 1, 1, 0, E_IDLE, "idle_start_ack");
    // Multiplier 1111 with start held high throughout.
    step(0, 1, 0, 1, E_LOAD, "m1111_load");
    for (int i = 1; i <= 4; i++) step(0, 1, 0, 1, E_OPA, $sformatf("m1111_op%0d", i));
    for (int i = 1; i <= 10; i++) step(0, 1, 0, 0, E_DONE, $sformatf("m1111_done_hold%0d", i));
    step(0, 1, 1, 0, E_DONE, "m1111_done_ack");
    step(0, 1, 0, 0, E_IDLE, "reenter_idle");
    // Multiplier 0000: restart from held start.
    step(0, 0, 0, 0, E_LOAD, "m0000_load");
    for (int i = 1; i <= 4; i++) step(0, 0, 0, 0, E_OPS, $sformatf("m0000_op%0d", i));
    step(0, 0, 1, 0, E_DONE, "m0000_done");
    // Reset during the 2nd OP cycle.
    step(0, 1, 0, 0, E_IDLE, "rst_mid_idle");
    step(0, 0, 0, 0, E_LOAD, "rst_mid_load");
    step(0, 0, 0, 0, E_OPS,  "rst_mid_op1");
    step(1, 0, 0, 1, E_OPA,  "rst_mid_op2");
    step(0, 0, 0, 0, E_IDLE, "rst_mid_after1");
    step(0, 0, 0, 0, E_IDLE, "rst_mid_after2");
    step(0, 0, 0, 0, E_IDLE, "rst_mid_after3");
`ifdef MULT_CONTROL_ABORT_EN
    // Abort in the 3rd OP cycle.
    step(0, 1, 0, 0, E_IDLE, "abort_idle");
    step(0, 0, 0, 0, E_LOAD, "abort_load");
    step(0, 0, 0, 1, E_OPA,  "abort_op1");
    step(0, 0, 0, 0, E_OPS,  "abort_op2");
    step(0, 0, 0, 1, E_OPA,  "abort_op3");
    abort = 1'b1;
    step(0, 0, 0, 0, E_IDLE, "abort_after1");
    abort = 1'b0;
    step(0, 1, 0, 0, E_IDLE, "abort_after2");
    // Abort in DONE has no effect.
    step(0, 0, 0, 0, E_LOAD, "abort_done_load");
    for (int i = 1; i <= 4; i++) step(0, 0, 0, 0, E_OPS, $sformatf("abort_done_op%0d", i));
    step(0, 0, 0, 0, E_DONE, "abort_done1");
    abort = 1'b1;
    step(0, 0, 1, 0, E_DONE, "abort_done2");
    abort = 1'b0;
    step(0, 0, 0, 0, E_IDLE, "abort_done_ack");
`endif
    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clock);
    @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending items required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
